// File: rtl/sap_control_sequencer_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, control-word bit
// indices, T-state indices and the run/halt state type.
package sap_control_sequencer_pkg;

    localparam int CTRL_W = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Control-word bit positions, MSB first
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    typedef enum logic {
        RUN_ST  = 1'b0,
        HALT_ST = 1'b1
    } run_state_e;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        logic [CTRL_W-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Opcode/flag inputs and control-word outputs between the sequencer (master)
// and the datapath blocks it strobes (slave).
interface sap_control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    import sap_control_sequencer_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                carry_flag;
    logic                zero_flag;
    logic [CTRL_W-1:0]   ctrl;
    logic [2:0]          step;
    logic                halted;

    modport master (
        input  opcode,
        input  carry_flag,
        input  zero_flag,
        output ctrl,
        output step,
        output halted
    );

    modport slave (
        output opcode,
        output carry_flag,
        output zero_flag,
        input  ctrl,
        input  step,
        input  halted
    );

endinterface

// File: rtl/sap_control_sequencer_step.sv
// T-state step counter with halt latch: wraps at STEPS-1, freezes at T0 once
// halt is requested, cleared asynchronously by clr_n.
module sap_step_counter
    import sap_control_sequencer_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       halt_req,
    output logic [2:0] step,
    output logic       halted
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    run_state_e state_reg, state_next;
    logic [2:0] step_reg, step_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= RUN_ST;
            step_reg  <= T0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        case (state_reg)
            RUN_ST: begin
                if (halt_req) begin
                    state_next = HALT_ST;
                    step_next  = T0;
                end else if (step_reg == LAST_STEP) begin
                    step_next = T0;
                end else begin
                    step_next = step_reg + 3'd1;
                end
            end
            HALT_ST: begin
                // Only clr_n leaves the halted state
                step_next = T0;
            end
            default: begin
                state_next = RUN_ST;
                step_next  = T0;
            end
        endcase
    end

    assign step   = step_reg;
    assign halted = (state_reg == HALT_ST);

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state counter plus microcode decode producing the
// 16-bit control word. Define SAP_COND_JUMP_EN to enable JC/JZ decode.
module sap_control_sequencer
    import sap_control_sequencer_pkg::*;
#(
    parameter int STEPS    = 5,
    parameter int OPCODE_W = 4
) (
    input  logic                    clk,
    input  logic                    clr_n,
    sap_control_sequencer_if.master bus
);

    logic [2:0]        step;
    logic              halted;
    logic              halt_req;
    logic [3:0]        op;
    logic [CTRL_W-1:0] ctrl_dec;

    assign op       = bus.opcode[3:0];
    assign halt_req = (step == T2) && (op == OP_HLT) && !halted;

    sap_step_counter #(
        .STEPS (STEPS)
    ) u_step (
        .clk      (clk),
        .clr_n    (clr_n),
        .halt_req (halt_req),
        .step     (step),
        .halted   (halted)
    );

`ifndef SAP_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = bus.carry_flag ^ bus.zero_flag;
`endif

    always_comb begin
        ctrl_dec = '0;
        if (halted) begin
            ctrl_dec = cbit(CTRL_HLT);
        end else begin
            case (step)
                T0: ctrl_dec = cbit(CTRL_CO) | cbit(CTRL_MI);
                T1: ctrl_dec = cbit(CTRL_RO) | cbit(CTRL_II) | cbit(CTRL_CE);
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA:
                            ctrl_dec = cbit(CTRL_IO) | cbit(CTRL_MI);
                        OP_LDI: ctrl_dec = cbit(CTRL_IO) | cbit(CTRL_AI);
                        OP_JMP: ctrl_dec = cbit(CTRL_IO) | cbit(CTRL_J);
`ifdef SAP_COND_JUMP_EN
                        OP_JC: begin
                            if (bus.carry_flag)
                                ctrl_dec = cbit(CTRL_IO) | cbit(CTRL_J);
                        end
                        OP_JZ: begin
                            if (bus.zero_flag)
                                ctrl_dec = cbit(CTRL_IO) | cbit(CTRL_J);
                        end
`endif
                        OP_OUT: ctrl_dec = cbit(CTRL_AO) | cbit(CTRL_OI);
                        OP_HLT: ctrl_dec = cbit(CTRL_HLT);
                        default: ctrl_dec = '0;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA:         ctrl_dec = cbit(CTRL_RO) | cbit(CTRL_AI);
                        OP_ADD, OP_SUB: ctrl_dec = cbit(CTRL_RO) | cbit(CTRL_BI);
                        OP_STA:         ctrl_dec = cbit(CTRL_AO) | cbit(CTRL_RI);
                        default:        ctrl_dec = '0;
                    endcase
                end
                T4: begin
                    case (op)
                        OP_ADD:  ctrl_dec = cbit(CTRL_EO) | cbit(CTRL_AI) | cbit(CTRL_FI);
                        OP_SUB:  ctrl_dec = cbit(CTRL_EO) | cbit(CTRL_SU) | cbit(CTRL_AI)
                                          | cbit(CTRL_FI);
                        default: ctrl_dec = '0;
                    endcase
                end
                // T5..T7 exist only for STEPS > 5 and are idle
                default: ctrl_dec = '0;
            endcase
        end
    end

    // Reset blanks the control word immediately, not at the next edge
    assign bus.ctrl   = clr_n ? ctrl_dec : '0;
    assign bus.step   = step;
    assign bus.halted = halted;

endmodule
